// File: rtl/tv_response_checker.sv
// Response checker for streamed test vectors: masked compare of obs/exp,
// with test/error counters, saturation flag and first-failure capture.
module tv_response_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] obs,
  input  logic [DATA_W-1:0] exp,
  input  logic [DATA_W-1:0] mask,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  test_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              cnt_sat,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_obs,
  output logic [DATA_W-1:0] first_err_exp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic xfer;
  logic mism;
  logic launch;
  logic test_full;
  logic err_full;

  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pass      = done && (err_cnt == '0);
  assign xfer      = in_valid && in_ready;
  assign mism      = |((obs ^ exp) & mask);
  assign launch    = start && (state != RUN);
  assign test_full = &test_cnt;
  assign err_full  = &err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (xfer && in_last) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_cnt      <= '0;
      err_cnt       <= '0;
      cnt_sat       <= 1'b0;
      err_pulse     <= 1'b0;
      first_err_idx <= '0;
      first_err_obs <= '0;
      first_err_exp <= '0;
    end else if (launch) begin
      test_cnt      <= '0;
      err_cnt       <= '0;
      cnt_sat       <= 1'b0;
      err_pulse     <= 1'b0;
      first_err_idx <= '0;
      first_err_obs <= '0;
      first_err_exp <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (xfer) begin
        if (test_full) cnt_sat  <= 1'b1;
        else           test_cnt <= test_cnt + CNT_W'(1);
        if (mism) begin
          err_pulse <= 1'b1;
          if (err_full) cnt_sat <= 1'b1;
          else          err_cnt <= err_cnt + CNT_W'(1);
          // err_cnt saturates rather than wraps, so zero means no prior failure
          if (err_cnt == '0) begin
            first_err_idx <= test_cnt;
            first_err_obs <= obs;
            first_err_exp <= exp;
          end
        end
      end
    end
  end

endmodule
